// File: rtl/sym_fir_seq.sv
// Time-multiplexed symmetric FIR filter: one folded multiply-accumulate per cycle,
// internal delay line, valid/ready handshakes and double-buffered coefficients.
module sym_fir_seq #(
   parameter int WIDTH     = 12,
   parameter int TAPS      = 19,
   parameter int COEF_W    = 12,
   parameter int OUT_SHIFT = 11,
   parameter int SAT       = 1,
   localparam int NFOLD    = (TAPS + 1) / 2,
   localparam int ACC_W    = WIDTH + COEF_W + 1 + $clog2(NFOLD),
   localparam int AW       = $clog2(NFOLD)
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [WIDTH-1:0]  in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [WIDTH-1:0]  out_data,
   input  logic                     coef_we,
   input  logic [AW-1:0]            coef_addr,
   input  logic signed [COEF_W-1:0] coef_data,
   input  logic                     coef_commit,
   output logic                     busy
);

   localparam int TW = $clog2(TAPS);
   localparam int PW = WIDTH + COEF_W + 1;
   localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((1 <<< (WIDTH - 1)) - 1);
   localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   state_t                   state;
   state_t                   state_next;
   logic signed [WIDTH-1:0]  x      [TAPS];
   logic signed [COEF_W-1:0] shadow [NFOLD];
   logic signed [COEF_W-1:0] active [NFOLD];
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  acc_next;
   logic signed [ACC_W-1:0]  shifted;
   logic signed [WIDTH-1:0]  result;
   logic signed [WIDTH:0]    pre;
   logic signed [PW-1:0]     prod;
   logic [AW-1:0]            k;
   logic [TW-1:0]            lo_idx;
   logic [TW-1:0]            hi_idx;
   logic                     commit_pend;
   logic                     last_tap;
   logic                     accept;
   logic                     do_commit;
   logic                     addr_ok;

   assign busy    = (state != IDLE);
   assign addr_ok = ({1'b0, coef_addr} < (AW + 1)'(NFOLD));

   // State register; an asserted reset abandons any MAC sequence in flight
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   // Next-state and handshake decode; a pending commit steals one IDLE cycle from the input
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      accept     = 1'b0;
      do_commit  = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready  = !commit_pend;
            do_commit = commit_pend;
            accept    = in_valid && !commit_pend;
            if (accept) state_next = MAC;
         end
         MAC: begin
            if (last_tap) state_next = OUT;
         end
         OUT: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Folded tap k: pair x[k] with its mirror, except the centre tap which stands alone
   always_comb begin
      lo_idx   = TW'(k);
      hi_idx   = TW'(TAPS - 1) - TW'(k);
      last_tap = (k == AW'(NFOLD - 1));
      if (last_tap) pre = {x[lo_idx][WIDTH-1], x[lo_idx]};
      else          pre = {x[lo_idx][WIDTH-1], x[lo_idx]} + {x[hi_idx][WIDTH-1], x[hi_idx]};
      prod     = $signed(PW'(pre)) * $signed(PW'(active[k]));
      acc_next = acc + ACC_W'(prod);
      shifted  = acc_next >>> OUT_SHIFT;
      result   = shifted[WIDTH-1:0];
      if (SAT != 0) begin
         if (shifted > MAX_V)      result = MAX_V[WIDTH-1:0];
         else if (shifted < MIN_V) result = MIN_V[WIDTH-1:0];
      end
   end

   // Delay line, accumulator and output register; the result is captured on the last MAC edge
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < TAPS; i++) x[i] <= '0;
         acc       <= '0;
         k         <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (accept) begin
            x[0] <= in_data;
            for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
            acc <= '0;
            k   <= '0;
         end else if (state == MAC) begin
            acc <= acc_next;
            if (last_tap) begin
               out_data  <= result;
               out_valid <= 1'b1;
            end else begin
               k <= k + AW'(1);
            end
         end else if (state == OUT && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Coefficient banks: shadow is writable any time, active is refreshed only from IDLE
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NFOLD; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         commit_pend <= 1'b0;
      end else begin
         if (coef_we && addr_ok) shadow[coef_addr] <= coef_data;
         if (do_commit) begin
            for (int i = 0; i < NFOLD; i++) active[i] <= shadow[i];
         end
         if (coef_commit)    commit_pend <= 1'b1;
         else if (do_commit) commit_pend <= 1'b0;
      end
   end

endmodule
